dht11_uart_tx: RTL and testbench

- Downstream consumer of the DHT11 top's ASCII byte stream (`ascii` with `go_ascii` strobe).
- Buffers each byte in a small FIFO and serialises it as 8N1 UART on `tx`, so the sensor path never stalls.
- Sits between the DHT11 top and the board's USB-UART pin.
- Bursts from the formatter (several bytes on consecutive cycles) are absorbed by the FIFO.

---
 rtl/dht11_uart_pkg.sv | 19 +
 rtl/byte_fifo.sv | 53 +++++
 rtl/dht11_uart_tx.sv | 143 ++++++++++++++
 tb/tb_dht11_uart_tx.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dht11_uart_pkg.sv
// Shared constants and types for the DHT11 ASCII-to-UART transmitter.
package dht11_uart_pkg;

  // One frame is a start bit, eight data bits and a stop bit.
  localparam int FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // Clocks per UART bit (integer division, truncating).
  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Single-clock byte FIFO. A push into a full FIFO is accepted only when a
// pop happens on the same edge; a pop of an empty FIFO is ignored.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage array: written on accepted pushes, contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dht11_uart_tx.sv
// Buffers ASCII bytes from the DHT11 formatter and sends them as 8N1 UART.
// Handshake: go_ascii is a fire-and-forget strobe with no ready. The byte is
// stored if the FIFO has room (or frees a slot on the same edge); otherwise
// it is dropped and the sticky overflow flag records the loss.
module dht11_uart_tx import dht11_uart_pkg::*; #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go_ascii,
  input  logic [7:0] ascii,
  output logic       tx,
  output logic       tx_busy,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int             DIV       = calc_div(CLK_HZ, BAUD);
  localparam int             CW        = $clog2(DIV + 1);
  localparam int             AW        = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0]  BAUD_LAST = CW'(DIV - 1);
  // Index of the last data bit: frame minus start and stop, minus one.
  localparam logic [2:0]     LAST_BIT  = 3'(FRAME_BITS - 3);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [7:0]    sh_q, sh_d;
  logic [2:0]    bit_q, bit_d;
  logic          tx_q, tx_d;
  logic          overflow_q;
  logic          pop;
  logic [7:0]    fifo_dout;
  logic [AW:0]   fifo_count;
  logic          fifo_empty;
  logic          fifo_full_w;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (go_ascii),
    .pop   (pop),
    .din   (ascii),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full_w),
    .empty (fifo_empty)
  );

  assign tx        = tx_q;
  assign fifo_full = fifo_full_w;
  assign overflow  = overflow_q;
  assign tx_busy   = (state_q != IDLE) || (fifo_count != '0);

  // Next-state, baud counting, shifting and FIFO pop decision.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          sh_d    = fifo_dout;
          bit_d   = '0;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          sh_d   = {1'b0, sh_q[7:1]};
          if (bit_q == LAST_BIT) state_d = STOP;
          else                   bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          // Chain straight into the next start bit when more data waits.
          if (!fifo_empty) begin
            pop     = 1'b1;
            sh_d    = fifo_dout;
            bit_d   = '0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Line level follows the state being entered so tx is glitch-free.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // FSM, datapath and line registers; reset abandons any frame at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      sh_q    <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  // Sticky loss flag: set when a strobe finds the FIFO full with no pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q <= 1'b0;
    end else if (go_ascii && fifo_full_w && !pop) begin
      overflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dht11_uart_tx.sv
// Bench for dht11_uart_tx: frame-position reference model, UART line decoder
// with an expected-byte queue, directed scenarios and random bursts.
module tb_dht11_uart_tx;

  localparam int CLK_HZ = 100;
  localparam int BAUD   = 10;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int DEPTH  = 4;
  localparam int FRAME  = 10 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       go_ascii = 1'b0;
  logic [7:0] ascii = 8'h00;
  logic       tx;
  logic       tx_busy;
  logic       fifo_full;
  logic       overflow;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model state: queued bytes, frame in flight and its bit-time position.
  logic [7:0] m_q[$];
  logic [7:0] m_byte;
  bit         m_busy;
  int         m_pos;
  bit         m_ovf;

  logic [7:0] exp_q[$];
  logic [7:0] dec_log[$];
  logic [7:0] seq [8];

  dht11_uart_tx #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .go_ascii  (go_ascii),
    .ascii     (ascii),
    .tx        (tx),
    .tx_busy   (tx_busy),
    .fifo_full (fifo_full),
    .overflow  (overflow)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- check helpers ----------------
  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h want %02h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line level implied by the position inside the current frame.
  function automatic logic exp_tx();
    int b;
    if (!m_busy) return 1'b1;
    b = m_pos / DIV;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_byte[b-1];
    return 1'b1;
  endfunction

  // ---------------- reference model ----------------
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst) begin
        m_q.delete();
        exp_q.delete();
        m_busy = 0;
        m_pos  = 0;
        m_ovf  = 0;
      end else begin
        // A frame lasts FRAME clocks; when it ends (or the line is idle)
        // the oldest waiting byte starts the next one.
        if (m_busy && m_pos < FRAME - 1) begin
          m_pos++;
        end else begin
          m_busy = 0;
          if (m_q.size() > 0) begin
            m_byte = m_q.pop_front();
            m_busy = 1;
            m_pos  = 0;
          end
        end
        if (go_ascii) begin
          if (m_q.size() < DEPTH) begin
            m_q.push_back(ascii);
            exp_q.push_back(ascii);
          end else begin
            m_ovf = 1;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("tx_in_reset", tx, 1'b1);
        chk("busy_in_reset", tx_busy, 1'b0);
        chk("full_in_reset", fifo_full, 1'b0);
        chk("ovf_in_reset", overflow, 1'b0);
      end else begin
        chk("tx", tx, exp_tx());
        chk("tx_busy", tx_busy, m_busy || (m_q.size() != 0));
        chk("fifo_full", fifo_full, m_q.size() == DEPTH);
        chk("overflow", overflow, m_ovf);
      end
    end
  end

  // ---------------- line decoder / scoreboard ----------------
  initial begin
    bit         act;
    int         c;
    logic [7:0] d;
    act = 0;
    c   = 0;
    d   = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        act = 0;
      end else if (!act) begin
        if (tx == 1'b0) begin
          act = 1;
          c   = 0;
        end
      end else begin
        c++;
        if (c == DIV / 2) chk("start_bit", tx, 1'b0);
        if (c >= DIV && c < 9 * DIV && (c % DIV) == DIV / 2) d[c / DIV - 1] = tx;
        if (c == 9 * DIV + DIV / 2) begin
          act = 0;
          chk("stop_bit", tx, 1'b1);
          dec_log.push_back(d);
          if (exp_q.size() == 0) begin
            chk8("byte_unexpected", d, 8'hxx);
          end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            chk8("byte_order", d, e);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Entered at a negedge; strobes seq[0..n-1] on consecutive rising edges.
  task automatic drive_seq(input int n);
    for (int i = 0; i < n; i++) begin
      go_ascii = 1'b1;
      ascii    = seq[i];
      @(negedge clk);
    end
    go_ascii = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (tx_busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (tx_busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_timeout: tx_busy=%b after %0d cycles, want 0", tx_busy, n);
    end
  endtask

  task automatic check_log(input int n);
    chk_int("decoded_count", dec_log.size(), n);
    for (int i = 0; i < n && i < dec_log.size(); i++) chk8("decoded_byte", dec_log[i], seq[i]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset held for three cycles.
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rel_tx", tx, 1'b1);
    chk("rel_busy", tx_busy, 1'b0);
    chk("rel_full", fifo_full, 1'b0);
    chk("rel_ovf", overflow, 1'b0);

    // Single byte 0x35: start at N+1, LSB (1) at N+11, idle after N+101.
    dec_log.delete();
    seq[0] = 8'h35;
    drive_seq(1);
    chk("single_n_tx", tx, 1'b1);
    chk("single_n_busy", tx_busy, 1'b1);
    @(negedge clk);
    chk("single_start_n1", tx, 1'b0);
    repeat (9) @(negedge clk);
    chk("single_start_n10", tx, 1'b0);
    @(negedge clk);
    chk("single_bit0_n11", tx, 1'b1);
    repeat (89) @(negedge clk);
    chk("single_stop_n100", tx, 1'b1);
    chk("single_busy_n100", tx_busy, 1'b1);
    @(negedge clk);
    chk("single_busy_n101", tx_busy, 1'b0);
    check_log(1);

    // Burst of three: frames contiguous at N+1, N+101, N+201.
    dec_log.delete();
    seq[0] = 8'h32; seq[1] = 8'h37; seq[2] = 8'h0D;
    drive_seq(3);
    repeat (98) @(negedge clk);
    chk("burst_stop_n100", tx, 1'b1);
    @(negedge clk);
    chk("burst_start_n101", tx, 1'b0);
    repeat (99) @(negedge clk);
    chk("burst_stop_n200", tx, 1'b1);
    @(negedge clk);
    chk("burst_start_n201", tx, 1'b0);
    repeat (99) @(negedge clk);
    chk("burst_busy_n300", tx_busy, 1'b1);
    @(negedge clk);
    chk("burst_busy_n301", tx_busy, 1'b0);
    check_log(3);

    // Full FIFO with a push on the pop edge at the end of the first frame.
    dec_log.delete();
    seq[0] = 8'h50; seq[1] = 8'h51; seq[2] = 8'h52; seq[3] = 8'h53;
    seq[4] = 8'h54; seq[5] = 8'h5A;
    drive_seq(5);
    chk("pp_full_n4", fifo_full, 1'b1);
    repeat (96) @(negedge clk);
    chk("pp_full_n100", fifo_full, 1'b1);
    go_ascii = 1'b1;
    ascii    = seq[5];
    @(negedge clk);
    go_ascii = 1'b0;
    chk("pp_full_n101", fifo_full, 1'b1);
    chk("pp_ovf_n101", overflow, 1'b0);
    chk("pp_start_n101", tx, 1'b0);
    wait_idle(1000);
    check_log(6);

    // Overflow: six strobes, the sixth is dropped.
    dec_log.delete();
    for (int i = 0; i < 6; i++) seq[i] = 8'h41 + 8'(i);
    drive_seq(6);
    chk("ovf_full_n5", fifo_full, 1'b1);
    chk("ovf_set_n5", overflow, 1'b1);
    wait_idle(1000);
    check_log(5);
    chk("ovf_sticky", overflow, 1'b1);

    // Reset during data bit 3, then a clean frame.
    seq[0] = 8'h77;
    drive_seq(1);
    repeat (44) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_tx", tx, 1'b1);
    chk("mid_rst_busy", tx_busy, 1'b0);
    chk("mid_rst_full", fifo_full, 1'b0);
    chk("mid_rst_ovf", overflow, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    dec_log.delete();
    seq[0] = 8'h31;
    drive_seq(1);
    wait_idle(300);
    check_log(1);

    // Random bursts with random gaps, checked by model and scoreboard.
    for (int k = 0; k < 20; k++) begin
      int gap;
      int len;
      gap = $urandom_range(0, 160);
      len = $urandom_range(1, 6);
      repeat (gap) @(negedge clk);
      for (int j = 0; j < len; j++) begin
        go_ascii = 1'b1;
        ascii    = 8'($urandom_range(0, 255));
        @(negedge clk);
      end
      go_ascii = 1'b0;
    end
    wait_idle(2000);
    chk_int("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
